// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results win the write port, multi-cycle results queue in a FIFO.
// Define WB_SCOREBOARD_EN to compile in the pending-register scoreboard; otherwise pending reads 0.
module wb_arbiter #(
    parameter int unsigned BITSIZE    = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alu_valid,
    input  logic [4:0]                      alu_sel,
    input  logic [BITSIZE-1:0]              alu_data,
    input  logic                            mc_valid,
    output logic                            mc_ready,
    input  logic [4:0]                      mc_sel,
    input  logic [BITSIZE-1:0]              mc_data,
    input  logic                            issue_valid,
    input  logic [4:0]                      issue_sel,
    output logic [31:0]                     pending,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            WriteEnable,
    output logic [4:0]                      WriteSelect,
    output logic [BITSIZE-1:0]              WriteData
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SelW = 5;

    typedef struct packed {
        logic [SelW-1:0]    sel;
        logic [BITSIZE-1:0] data;
    } entry_t;

    entry_t          fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0] headPtr;
    logic [PtrW-1:0] tailPtr;
    logic [CntW-1:0] count;
    entry_t          headEntry;

    logic aluWin;
    logic pushEn;
    logic popEn;

    assign mc_ready   = (count < CntW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign headEntry  = fifoMem[headPtr];

    // Register-0 beats still complete the handshake; they are just never stored.
    always_comb begin
        aluWin = alu_valid && (alu_sel != '0);
        pushEn = mc_valid && mc_ready && (mc_sel != '0);
        popEn  = !aluWin && (count != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (pushEn) tailPtr <= tailPtr + PtrW'(1);
            if (popEn)  headPtr <= headPtr + PtrW'(1);
            case ({pushEn, popEn})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (pushEn) fifoMem[tailPtr] <= '{sel: mc_sel, data: mc_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WriteEnable <= 1'b0;
            WriteSelect <= '0;
            WriteData   <= '0;
        end else begin
            WriteEnable <= aluWin || popEn;
            if (aluWin) begin
                WriteSelect <= alu_sel;
                WriteData   <= alu_data;
            end else if (popEn) begin
                WriteSelect <= headEntry.sel;
                WriteData   <= headEntry.data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic        wbFromMc;
    logic [31:0] pendingNext;

    // Clear on the commit edge of a multi-cycle write; a same-edge issue re-sets the bit.
    always_comb begin
        pendingNext = pending;
        if (WriteEnable && wbFromMc) pendingNext[WriteSelect] = 1'b0;
        if (issue_valid && (issue_sel != '0)) pendingNext[issue_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbFromMc <= 1'b0;
            pending  <= '0;
        end else begin
            wbFromMc <= popEn;
            pending  <= pendingNext;
        end
    end
`else
    logic unusedIssue;

    assign pending     = '0;
    assign unusedIssue = ^{issue_valid, issue_sel};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: reference model feeds an expected-write queue compared every cycle.
module tb_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
    localparam bit SbEn = 1'b1;
`else
    localparam bit SbEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_sel;
    logic [31:0] alu_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_sel;
    logic [31:0] mc_data;
    logic        issue_valid;
    logic [4:0]  issue_sel;
    logic [31:0] pending;
    logic [2:0]  fifo_count;
    logic        WriteEnable;
    logic [4:0]  WriteSelect;
    logic [31:0] WriteData;

    int tests = 0;
    int fails = 0;

    logic [37:0] expQ[$];
    logic [36:0] modelFifo[$];
    logic [31:0] rf [32];

    wb_arbiter #(.BITSIZE(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_sel(mc_sel), .mc_data(mc_data),
        .issue_valid(issue_valid), .issue_sel(issue_sel),
        .pending(pending), .fifo_count(fifo_count),
        .WriteEnable(WriteEnable), .WriteSelect(WriteSelect), .WriteData(WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ALU first, then oldest queued beat; push acceptance uses pre-edge occupancy.
    always @(posedge clk) begin
        logic        aluW;
        logic        rdy;
        logic [37:0] e;
        if (!reset) begin
            expQ.push_back(38'd0);
        end else begin
            aluW = alu_valid && (alu_sel != 5'd0);
            rdy  = modelFifo.size() < 4;
            if (aluW)                      e = {1'b1, alu_sel, alu_data};
            else if (modelFifo.size() > 0) e = {1'b1, modelFifo.pop_front()};
            else                           e = 38'd0;
            expQ.push_back(e);
            if (mc_valid && rdy && (mc_sel != 5'd0)) modelFifo.push_back({mc_sel, mc_data});
        end
    end

    always @(negedge reset) begin
        expQ.delete();
        modelFifo.delete();
    end

    always @(posedge clk) begin
        if (reset && WriteEnable) rf[WriteSelect] <= WriteData;
    end

    always @(negedge clk) begin
        logic [37:0] e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            tests++;
            if (e[37] == 1'b0) begin
                if (WriteEnable !== 1'b0) begin
                    fails++;
                    $display("FAIL wb_idle t=%0t: WriteEnable=%b expected 0", $time, WriteEnable);
                end
            end else if ({WriteEnable, WriteSelect, WriteData} !== e) begin
                fails++;
                $display("FAIL wb_write t=%0t: got we=%b sel=%0d data=%h expected we=1 sel=%0d data=%h",
                         $time, WriteEnable, WriteSelect, WriteData, e[36:32], e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alu_valid = 0; alu_sel = 0; alu_data = 0;
        mc_valid = 0; mc_sel = 0; mc_data = 0;
        issue_valid = 0; issue_sel = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        step();
        step();
        tests++;
        if ({WriteEnable, WriteSelect, WriteData} !== 38'd0) begin
            fails++;
            $display("FAIL reset_wb: got %b/%0d/%h expected all zero", WriteEnable, WriteSelect, WriteData);
        end
        tests++;
        if (pending !== 32'd0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: pending=%h count=%0d expected 0/0", pending, fifo_count);
        end
        tests++;
        if (mc_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: mc_ready=%b expected 1", mc_ready);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_sel = 5; alu_data = 32'hDEADBEEF;
        step();
        tests++;
        if ({WriteEnable, WriteSelect, WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL alu_write: got %b/%0d/%h expected 1/5/deadbeef", WriteEnable, WriteSelect, WriteData);
        end
        alu_sel = 0; alu_data = 32'h11111111;
        step();
        tests++;
        if (WriteEnable !== 1'b0) begin
            fails++;
            $display("FAIL alu_r0_dropped: WriteEnable=%b expected 0", WriteEnable);
        end
        alu_valid = 0;
        step();
    endtask

    task automatic test_mc_latency();
        issue_valid = 1; issue_sel = 7;
        step();
        issue_valid = 0;
        tests++;
        if (pending !== (SbEn ? 32'h80 : 32'h0)) begin
            fails++;
            $display("FAIL issue_set: pending=%h expected %h", pending, SbEn ? 32'h80 : 32'h0);
        end
        mc_valid = 1; mc_sel = 7; mc_data = 32'h1234;
        step();
        mc_valid = 0;
        tests++;
        if (fifo_count !== 3'd1 || WriteEnable !== 1'b0) begin
            fails++;
            $display("FAIL mc_accept: count=%0d we=%b expected 1/0", fifo_count, WriteEnable);
        end
        step();
        tests++;
        if (WriteEnable !== 1'b1 || WriteSelect !== 5'd7 || fifo_count !== 3'd0 ||
            pending !== (SbEn ? 32'h80 : 32'h0)) begin
            fails++;
            $display("FAIL mc_pop: we=%b sel=%0d count=%0d pending=%h expected 1/7/0/%h",
                     WriteEnable, WriteSelect, fifo_count, pending, SbEn ? 32'h80 : 32'h0);
        end
        step();
        tests++;
        if (pending !== 32'h0 || rf[7] !== 32'h1234) begin
            fails++;
            $display("FAIL mc_commit: pending=%h rf7=%h expected 0/1234", pending, rf[7]);
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_sel = 5'(1 + i); alu_data = 32'(i);
            mc_valid = 1; mc_sel = 5'(10 + i); mc_data = 32'(8'hA0 + i);
            tests++;
            if (mc_ready !== 1'b1) begin
                fails++;
                $display("FAIL fill_ready%0d: mc_ready=%b expected 1", i, mc_ready);
            end
            step();
        end
        mc_valid = 0;
        tests++;
        if (fifo_count !== 3'd4 || mc_ready !== 1'b0) begin
            fails++;
            $display("FAIL full: count=%0d ready=%b expected 4/0", fifo_count, mc_ready);
        end
        alu_valid = 0;
        mc_valid = 1; mc_sel = 20; mc_data = 32'hBB;
        step();
        mc_valid = 0;
        tests++;
        if (fifo_count !== 3'd3 || mc_ready !== 1'b1 || WriteSelect !== 5'd10) begin
            fails++;
            $display("FAIL full_pop_push: count=%0d ready=%b sel=%0d expected 3/1/10",
                     fifo_count, mc_ready, WriteSelect);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            tests++;
            if (WriteEnable !== 1'b1 || WriteSelect !== 5'(10 + i) || fifo_count !== 3'(3 - i)) begin
                fails++;
                $display("FAIL drain%0d: we=%b sel=%0d count=%0d expected 1/%0d/%0d",
                         i, WriteEnable, WriteSelect, fifo_count, 10 + i, 3 - i);
            end
        end
        step();
        tests++;
        if (WriteEnable !== 1'b0) begin
            fails++;
            $display("FAIL drain_idle: WriteEnable=%b expected 0", WriteEnable);
        end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_sel = 7;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_sel = 2; alu_data = 32'(i);
            mc_valid = 1; mc_sel = 5'(11 + i); mc_data = 32'(8'hC0 + i);
            step();
            issue_valid = 0;
        end
        mc_valid = 0;
        tests++;
        if (fifo_count !== 3'd3 || pending !== (SbEn ? 32'h80 : 32'h0)) begin
            fails++;
            $display("FAIL pre_reset: count=%0d pending=%h expected 3/%h",
                     fifo_count, pending, SbEn ? 32'h80 : 32'h0);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({WriteEnable, WriteSelect, WriteData} !== 38'd0 || pending !== 32'd0 ||
            fifo_count !== 3'd0 || mc_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: we=%b sel=%0d data=%h pending=%h count=%0d ready=%b expected 0/0/0/0/0/1",
                     WriteEnable, WriteSelect, WriteData, pending, fifo_count, mc_ready);
        end
        alu_valid = 0;
        step();
        step();
        reset = 1'b1;
        step();
        tests++;
        if (WriteEnable !== 1'b0 || fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL post_reset: we=%b count=%0d expected 0/0", WriteEnable, fifo_count);
        end
        mc_valid = 1; mc_sel = 0; mc_data = 32'h55;
        tests++;
        if (mc_ready !== 1'b1) begin
            fails++;
            $display("FAIL r0_ready: mc_ready=%b expected 1", mc_ready);
        end
        step();
        mc_valid = 0;
        tests++;
        if (fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL r0_not_queued: count=%0d expected 0", fifo_count);
        end
        step();
        tests++;
        if (WriteEnable !== 1'b0) begin
            fails++;
            $display("FAIL r0_no_write: WriteEnable=%b expected 0", WriteEnable);
        end
    endtask

    task automatic test_set_wins();
        issue_valid = 1; issue_sel = 9;
        step();
        issue_valid = 0;
        mc_valid = 1; mc_sel = 9; mc_data = 32'h99;
        step();
        mc_valid = 0;
        step();
        issue_valid = 1; issue_sel = 9;
        step();
        issue_valid = 0;
        tests++;
        if (pending[9] !== SbEn || rf[9] !== 32'h99) begin
            fails++;
            $display("FAIL set_wins: pending9=%b rf9=%h expected %b/99", pending[9], rf[9], SbEn);
        end
        step();
        tests++;
        if (pending !== (SbEn ? 32'h200 : 32'h0)) begin
            fails++;
            $display("FAIL set_hold: pending=%h expected %h", pending, SbEn ? 32'h200 : 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mc_latency();
        test_fifo_full();
        test_reset_mid();
        test_set_wins();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
